// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/DMA data-memory arbiter with starvation guard and sticky error record
module dmem_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int AW       = 13
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_wena,
    input  logic [1:0]    cpu_wbh,
    input  logic [AW-1:0] cpu_addr,
    input  logic [31:0]   cpu_wdata,
    output logic          cpu_ack,
    output logic [31:0]   cpu_rdata,
    output logic          cpu_err,
    input  logic          dma_req,
    input  logic          dma_wena,
    input  logic [1:0]    dma_wbh,
    input  logic [AW-1:0] dma_addr,
    input  logic [31:0]   dma_wdata,
    output logic          dma_ack,
    output logic [31:0]   dma_rdata,
    output logic          dma_err,
    output logic          mem_wena,
    output logic [1:0]    mem_wbh,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic          err_valid,
    output logic          err_src,
    output logic [AW-1:0] err_addr,
    input  logic          err_clr
);

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    logic [3:0]    starve_cnt;
    logic          dma_grant;
    logic          cpu_grant;
    logic          any_grant;
    logic          legal;
    logic          acc_err;
    logic          win_wena;
    logic [1:0]    win_wbh;
    logic [AW-1:0] win_addr;
    logic [31:0]   win_wdata;

    function automatic logic is_legal(input logic [1:0] wbh, input logic [1:0] lsb);
        case (wbh)
            2'b01:   is_legal = (lsb == 2'b00);
            2'b10:   is_legal = !lsb[0];
            2'b11:   is_legal = 1'b1;
            default: is_legal = 1'b0;
        endcase
    endfunction

    // rst gates the grant combinationally so an in-flight store is dropped before the negedge write
    assign dma_grant = !rst && dma_req && ((starve_cnt == WAIT_LIMIT) || !cpu_req);
    assign cpu_grant = !rst && cpu_req && !dma_grant;
    assign any_grant = dma_grant || cpu_grant;

    always_comb begin
        win_wena  = cpu_wena;
        win_wbh   = cpu_wbh;
        win_addr  = cpu_addr;
        win_wdata = cpu_wdata;
        if (dma_grant) begin
            win_wena  = dma_wena;
            win_wbh   = dma_wbh;
            win_addr  = dma_addr;
            win_wdata = dma_wdata;
        end
    end

    assign legal   = is_legal(win_wbh, win_addr[1:0]);
    assign acc_err = any_grant && !legal;

    always_comb begin
        mem_wena  = 1'b0;
        mem_wbh   = 2'b01;
        mem_addr  = '0;
        mem_wdata = '0;
        cpu_ack   = 1'b0;
        cpu_err   = 1'b0;
        cpu_rdata = '0;
        dma_ack   = 1'b0;
        dma_err   = 1'b0;
        dma_rdata = '0;
        if (any_grant) begin
            mem_wena  = win_wena && legal;
            mem_wbh   = win_wbh;
            mem_addr  = win_addr;
            mem_wdata = win_wdata;
        end
        if (cpu_grant) begin
            cpu_ack   = 1'b1;
            cpu_err   = !legal;
            cpu_rdata = legal ? mem_rdata : 32'd0;
        end
        if (dma_grant) begin
            dma_ack   = 1'b1;
            dma_err   = !legal;
            dma_rdata = legal ? mem_rdata : 32'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= 4'd0;
        end else if (dma_req && !dma_grant) begin
            if (starve_cnt < WAIT_LIMIT) starve_cnt <= starve_cnt + 4'd1;
        end else begin
            starve_cnt <= 4'd0;
        end
    end

    // A new error in the clearing cycle replaces the old record rather than being lost
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_valid <= 1'b0;
            err_src   <= 1'b0;
            err_addr  <= '0;
        end else if (acc_err && (!err_valid || err_clr)) begin
            err_valid <= 1'b1;
            err_src   <= dma_grant;
            err_addr  <= win_addr;
        end else if (err_clr) begin
            err_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter
module tb_dmem_arbiter;

    localparam int AW = 13;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_wena, dma_req, dma_wena, err_clr;
    logic [1:0]    cpu_wbh, dma_wbh;
    logic [AW-1:0] cpu_addr, dma_addr;
    logic [31:0]   cpu_wdata, dma_wdata;
    logic          cpu_ack, cpu_err, dma_ack, dma_err;
    logic [31:0]   cpu_rdata, dma_rdata;
    logic          mem_wena;
    logic [1:0]    mem_wbh;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;
    logic          err_valid, err_src;
    logic [AW-1:0] err_addr;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        src;
        logic        err;
        logic        chk_rd;
        logic [31:0] rdata;
    } exp_t;
    exp_t sb[$];

    logic [7:0]    mem [0:(1<<AW)-1];
    logic [AW-1:0] a1, a2, a3;

    always #5 clk = ~clk;

    dmem_arbiter #(.MAX_WAIT(4), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_wena(cpu_wena), .cpu_wbh(cpu_wbh), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .dma_req(dma_req), .dma_wena(dma_wena), .dma_wbh(dma_wbh), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_ack(dma_ack), .dma_rdata(dma_rdata), .dma_err(dma_err),
        .mem_wena(mem_wena), .mem_wbh(mem_wbh), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .err_valid(err_valid), .err_src(err_src), .err_addr(err_addr),
        .err_clr(err_clr)
    );

    // Byte-lane memory: right-aligned data, writes on negedge, combinational read
    assign a1 = mem_addr + 13'd1;
    assign a2 = mem_addr + 13'd2;
    assign a3 = mem_addr + 13'd3;

    always_comb begin
        case (mem_wbh)
            2'b01:   mem_rdata = {mem[a3], mem[a2], mem[a1], mem[mem_addr]};
            2'b10:   mem_rdata = {16'd0, mem[a1], mem[mem_addr]};
            2'b11:   mem_rdata = {24'd0, mem[mem_addr]};
            default: mem_rdata = 32'd0;
        endcase
    end

    always @(negedge clk) begin
        if (mem_wena) begin
            mem[mem_addr] <= mem_wdata[7:0];
            if (mem_wbh != 2'b11) mem[a1] <= mem_wdata[15:8];
            if (mem_wbh == 2'b01) begin
                mem[a2] <= mem_wdata[23:16];
                mem[a3] <= mem_wdata[31:24];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push(input logic src, input logic err, input logic chk_rd, input logic [31:0] rdata);
        exp_t e;
        e.src = src; e.err = err; e.chk_rd = chk_rd; e.rdata = rdata;
        sb.push_back(e);
    endtask

    task automatic cpu_set(input logic req, input logic wena, input logic [1:0] wbh,
                           input logic [AW-1:0] addr, input logic [31:0] wdata);
        cpu_req = req; cpu_wena = wena; cpu_wbh = wbh; cpu_addr = addr; cpu_wdata = wdata;
    endtask

    task automatic dma_set(input logic req, input logic wena, input logic [1:0] wbh,
                           input logic [AW-1:0] addr, input logic [31:0] wdata);
        dma_req = req; dma_wena = wena; dma_wbh = wbh; dma_addr = addr; dma_wdata = wdata;
    endtask

    // Called at posedge+1; samples at posedge+4, ahead of the negedge write
    task automatic sample();
        exp_t e;
        #3;
        if (cpu_ack || dma_ack) begin
            check("one_ack", 32'(cpu_ack && dma_ack), 32'd0);
            check("sb_unexp", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("sb_src", 32'(dma_ack), 32'(e.src));
                check("sb_err", 32'(dma_ack ? dma_err : cpu_err), 32'(e.err));
                if (e.chk_rd) check("sb_rdata", dma_ack ? dma_rdata : cpu_rdata, e.rdata);
            end
        end
        check("sb_miss", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    int exp_cnt [6] = '{0, 1, 2, 3, 4, 0};

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
        rst = 1'b1;
        err_clr = 1'b0;
        cpu_set(1'b1, 1'b1, 2'b01, 13'h100, 32'h11223344);
        dma_set(1'b1, 1'b0, 2'b01, 13'h010, 32'd0);
        next();

        // Reset holds everything off despite requests
        sample();
        check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        check("rst_dma_ack", 32'(dma_ack), 32'd0);
        check("rst_mem_wena", 32'(mem_wena), 32'd0);
        check("rst_err_valid", 32'(err_valid), 32'd0);
        check("rst_cpu_rdata", cpu_rdata, 32'd0);
        next();
        rst = 1'b0;

        // First cycle after reset: CPU wins
        push(1'b0, 1'b0, 1'b0, 32'd0);
        sample();
        check("post_rst_wena", 32'(mem_wena), 32'd1);
        next();

        // Word store then byte load
        dma_set(1'b0, 1'b0, 2'b01, 13'h000, 32'd0);
        cpu_set(1'b1, 1'b1, 2'b01, 13'h010, 32'hA1B2C3D4);
        push(1'b0, 1'b0, 1'b0, 32'd0);
        sample();
        check("st_wena", 32'(mem_wena), 32'd1);
        check("st_addr", 32'(mem_addr), 32'h010);
        check("st_wdata", mem_wdata, 32'hA1B2C3D4);
        next();
        cpu_set(1'b1, 1'b0, 2'b11, 13'h011, 32'd0);
        push(1'b0, 1'b0, 1'b1, 32'h000000C3);
        sample();
        check("ld_wena", 32'(mem_wena), 32'd0);
        next();
        cpu_set(1'b1, 1'b0, 2'b01, 13'h010, 32'd0);
        push(1'b0, 1'b0, 1'b1, 32'hA1B2C3D4);
        sample();
        next();

        // Starvation: CPU x4, DMA, CPU
        cpu_set(1'b1, 1'b0, 2'b11, 13'h010, 32'd0);
        dma_set(1'b1, 1'b0, 2'b01, 13'h010, 32'd0);
        for (int k = 0; k < 6; k++) begin
            if (k == 4) push(1'b1, 1'b0, 1'b1, 32'hA1B2C3D4);
            else        push(1'b0, 1'b0, 1'b1, 32'h000000D4);
            sample();
            check($sformatf("starve_%0d", k), 32'(dut.starve_cnt), 32'(exp_cnt[k]));
            next();
        end
        dma_set(1'b0, 1'b0, 2'b01, 13'h000, 32'd0);

        // Half store then DMA-alone half load
        cpu_set(1'b1, 1'b1, 2'b10, 13'h00A, 32'h0000BEEF);
        push(1'b0, 1'b0, 1'b0, 32'd0);
        sample();
        next();
        cpu_set(1'b0, 1'b0, 2'b01, 13'h000, 32'd0);
        dma_set(1'b1, 1'b0, 2'b10, 13'h00A, 32'd0);
        push(1'b1, 1'b0, 1'b1, 32'h0000BEEF);
        sample();
        check("dma_alone_cnt", 32'(dut.starve_cnt), 32'd0);
        next();
        dma_set(1'b0, 1'b0, 2'b01, 13'h000, 32'd0);
        sample();
        check("dma_alone_cnt2", 32'(dut.starve_cnt), 32'd0);
        next();

        // Misaligned half store is rejected and recorded
        cpu_set(1'b1, 1'b1, 2'b10, 13'h003, 32'h0000FFFF);
        push(1'b0, 1'b1, 1'b1, 32'd0);
        sample();
        check("mis_wena", 32'(mem_wena), 32'd0);
        next();
        cpu_set(1'b0, 1'b0, 2'b01, 13'h000, 32'd0);
        sample();
        check("mis_mem", 32'(mem[3]), 32'd0);
        check("mis_valid", 32'(err_valid), 32'd1);
        check("mis_src", 32'(err_src), 32'd0);
        check("mis_addr", 32'(err_addr), 32'h003);
        check("idle_wbh", 32'(mem_wbh), 32'd1);
        check("idle_addr", 32'(mem_addr), 32'd0);
        check("idle_wdata", mem_wdata, 32'd0);
        next();

        // Second error keeps the record; clear with coincident error reloads it
        dma_set(1'b1, 1'b0, 2'b01, 13'h006, 32'd0);
        push(1'b1, 1'b1, 1'b1, 32'd0);
        sample();
        next();
        dma_set(1'b0, 1'b0, 2'b01, 13'h000, 32'd0);
        sample();
        check("err2_valid", 32'(err_valid), 32'd1);
        check("err2_src", 32'(err_src), 32'd0);
        check("err2_addr", 32'(err_addr), 32'h003);
        next();
        err_clr = 1'b1;
        dma_set(1'b1, 1'b0, 2'b00, 13'h020, 32'd0);
        push(1'b1, 1'b1, 1'b1, 32'd0);
        sample();
        next();
        err_clr = 1'b0;
        dma_set(1'b0, 1'b0, 2'b01, 13'h000, 32'd0);
        sample();
        check("clr_set_valid", 32'(err_valid), 32'd1);
        check("clr_set_src", 32'(err_src), 32'd1);
        check("clr_set_addr", 32'(err_addr), 32'h020);
        next();
        err_clr = 1'b1;
        sample();
        next();
        err_clr = 1'b0;
        sample();
        check("clr_valid", 32'(err_valid), 32'd0);
        next();

        // Reset mid-store suppresses the write
        cpu_set(1'b1, 1'b1, 2'b01, 13'h040, 32'hDEADBEEF);
        #1 rst = 1'b1;
        #2;
        check("rst_mid_wena", 32'(mem_wena), 32'd0);
        check("rst_mid_ack", 32'(cpu_ack), 32'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        cpu_set(1'b0, 1'b0, 2'b01, 13'h000, 32'd0);
        next();
        cpu_set(1'b1, 1'b0, 2'b01, 13'h040, 32'd0);
        push(1'b0, 1'b0, 1'b1, 32'd0);
        sample();
        next();
        cpu_set(1'b0, 1'b0, 2'b01, 13'h000, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
